// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache
// Hits answer on the next edge; misses hold a level request until the memory strobe.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        fetch_en_i,
  input  logic [31:0] fetch_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;

  typedef enum logic {
    S_IDLE,
    S_MISS
  } state_t;

  state_t                state_q;
  logic [31:0]           data_q [LINES];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  logic [31:0]           miss_pc_q;

  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0]   f_tag;
  logic [INDEX_BITS-1:0] m_idx;
  logic [TAG_BITS-1:0]   m_tag;
  logic                  f_hit;
  logic                  fill_en;

  assign f_idx  = fetch_pc_i[INDEX_BITS+1:2];
  assign f_tag  = fetch_pc_i[ADDR_BITS-1:INDEX_BITS+2];
  assign m_idx  = miss_pc_q[INDEX_BITS+1:2];
  assign m_tag  = miss_pc_q[ADDR_BITS-1:INDEX_BITS+2];
  assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign busy_o = (state_q != S_IDLE);

  // A strobe coinciding with clear or reset must not touch the arrays.
  assign fill_en = rst_in && rdy_in && !clear && (state_q == S_MISS) && mem_valid_i;

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      data_q[m_idx] <= mem_data_i;
      tag_q[m_idx]  <= m_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      miss_pc_q    <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
    end else if (rdy_in) begin
      inst_valid_o <= 1'b0;
      if (clear) begin
        state_q   <= S_IDLE;
        mem_req_o <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fetch_en_i) begin
              if (f_hit) begin
                inst_valid_o <= 1'b1;
                inst_o       <= data_q[f_idx];
                inst_pc_o    <= fetch_pc_i;
              end else begin
                miss_pc_q  <= fetch_pc_i;
                mem_req_o  <= 1'b1;
                mem_addr_o <= {fetch_pc_i[31:2], 2'b00};
                state_q    <= S_MISS;
              end
            end
          end
          S_MISS: begin
            if (mem_valid_i) begin
              valid_q[m_idx] <= 1'b1;
              inst_valid_o   <= 1'b1;
              inst_o         <= mem_data_i;
              inst_pc_o      <= miss_pc_q;
              mem_req_o      <= 1'b0;
              state_q        <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
